// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared integer-core definitions: default data width,
//               architectural register indices (shared with sys_regs) and
//               writeback-entry field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Writeback entry layout: {rd, data}
    localparam int RD_W = 5;

    localparam logic [RD_W-1:0] X0  = 5'd0;
    localparam logic [RD_W-1:0] X1  = 5'd1;
    localparam logic [RD_W-1:0] X2  = 5'd2;
    localparam logic [RD_W-1:0] X3  = 5'd3;
    localparam logic [RD_W-1:0] X4  = 5'd4;
    localparam logic [RD_W-1:0] X5  = 5'd5;
    localparam logic [RD_W-1:0] X6  = 5'd6;
    localparam logic [RD_W-1:0] X7  = 5'd7;
    localparam logic [RD_W-1:0] X8  = 5'd8;
    localparam logic [RD_W-1:0] X9  = 5'd9;
    localparam logic [RD_W-1:0] X10 = 5'd10;
    localparam logic [RD_W-1:0] X11 = 5'd11;
    localparam logic [RD_W-1:0] X12 = 5'd12;
    localparam logic [RD_W-1:0] X13 = 5'd13;
    localparam logic [RD_W-1:0] X14 = 5'd14;
    localparam logic [RD_W-1:0] X15 = 5'd15;
    localparam logic [RD_W-1:0] X16 = 5'd16;
    localparam logic [RD_W-1:0] X17 = 5'd17;
    localparam logic [RD_W-1:0] X18 = 5'd18;
    localparam logic [RD_W-1:0] X19 = 5'd19;
    localparam logic [RD_W-1:0] X20 = 5'd20;
    localparam logic [RD_W-1:0] X21 = 5'd21;
    localparam logic [RD_W-1:0] X22 = 5'd22;
    localparam logic [RD_W-1:0] X23 = 5'd23;
    localparam logic [RD_W-1:0] X24 = 5'd24;
    localparam logic [RD_W-1:0] X25 = 5'd25;
    localparam logic [RD_W-1:0] X26 = 5'd26;
    localparam logic [RD_W-1:0] X27 = 5'd27;
    localparam logic [RD_W-1:0] X28 = 5'd28;
    localparam logic [RD_W-1:0] X29 = 5'd29;
    localparam logic [RD_W-1:0] X30 = 5'd30;
    localparam logic [RD_W-1:0] X31 = 5'd31;

    // x0 is hardwired to zero and must never be written or tracked.
    function automatic logic is_x0(input logic [RD_W-1:0] rd);
        return rd == X0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO buffering load writeback entries.
//               DEPTH must be a power of two (>= 2) so pointers wrap
//               naturally; the occupancy counter is one bit wider.
//               Head entry is presented combinationally (no bypass).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if a caller misbehaves.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    // Next pointer and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is not occupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_ctrl
// Description : Register-file writeback controller. Merges single-cycle ALU
//               results with buffered load results and issues one registered
//               write per cycle to sys_regs. x0 results are consumed but not
//               written.
//               Optional feature macro: WB_SCOREBOARD_EN - builds a pending-
//               load scoreboard driving hz_rs1/hz_rs2 for RAW stalls. When
//               undefined, hz_* are tied low and iss_*/chk_* are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    // ALU result channel
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    // Load result channel
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    // Issue-stage hazard interface
    input  logic            iss_valid,
    input  logic            iss_is_load,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    output logic            hz_rs1,
    output logic            hz_rs2,
    // sys_regs write port
    output logic            wr_en,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] wr_data
);

    localparam int ENTRY_W = RD_W + XLEN;

    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [RD_W-1:0]     head_rd;
    logic [XLEN-1:0]     head_data;

    logic                ld_push;
    logic                alu_xfer;
    logic                ld_pop;
    logic                cmt_valid;
    logic [RD_W-1:0]     cmt_rd;
    logic [XLEN-1:0]     cmt_data;
    logic                cmt_write;

    logic                wr_en_q,   wr_en_d;
    logic [RD_W-1:0]     rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;

    // ------------------------------------------------------------------
    // Load buffer
    // ------------------------------------------------------------------
    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ld_push),
        .pop_i   (ld_pop),
        .data_i  ({ld_rd, ld_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign head_rd   = fifo_head[ENTRY_W-1 -: RD_W];
    assign head_data = fifo_head[XLEN-1:0];

    // ------------------------------------------------------------------
    // Handshakes and arbitration
    // ------------------------------------------------------------------
    // Holding the ALU off while full guarantees the head drains, so both
    // producers see the same backpressure signal.
    assign alu_ready = !fifo_full;
    assign ld_ready  = !fifo_full;

    assign ld_push   = ld_valid  && !fifo_full;
    assign alu_xfer  = alu_valid && !fifo_full;
    // When full, alu_xfer is forced low so the head wins automatically.
    assign ld_pop    = !alu_xfer && !fifo_empty;

    assign cmt_valid = alu_xfer || ld_pop;
    assign cmt_rd    = alu_xfer ? alu_rd   : head_rd;
    assign cmt_data  = alu_xfer ? alu_data : head_data;
    assign cmt_write = cmt_valid && !is_x0(cmt_rd);

    // Output stage next-state: address/data hold when nothing is written.
    always_comb begin
        wr_en_d   = cmt_write;
        rd_addr_d = rd_addr_q;
        wr_data_d = wr_data_q;
        if (cmt_write) begin
            rd_addr_d = cmt_rd;
            wr_data_d = cmt_data;
        end
    end

    // Registered write port so address/data are stable for the whole cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_data = wr_data_q;

    // ------------------------------------------------------------------
    // Pending-load scoreboard
    // ------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
    logic [31:0] pending_q, pending_d;
    logic        ld_cmt_rs1;
    logic        ld_cmt_rs2;

    // Clear on load commit first, then set, so a same-cycle re-issue wins.
    always_comb begin
        pending_d = pending_q;
        if (ld_pop && !is_x0(head_rd)) begin
            pending_d[head_rd] = 1'b0;
        end
        if (iss_valid && iss_is_load && !is_x0(iss_rd)) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    // Pending vector register; reset drops all in-flight loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign ld_cmt_rs1 = ld_pop && (head_rd == chk_rs1);
    assign ld_cmt_rs2 = ld_pop && (head_rd == chk_rs2);

    assign hz_rs1 = !is_x0(chk_rs1) && (pending_q[chk_rs1] || ld_cmt_rs1);
    assign hz_rs2 = !is_x0(chk_rs2) && (pending_q[chk_rs2] || ld_cmt_rs2);
`else
    logic w_unused_sb;

    // Hazard tracking is not built; its inputs are intentionally ignored.
    assign w_unused_sb = ^{iss_valid, iss_is_load, iss_rd, chk_rs1, chk_rs2};
    assign hz_rs1      = 1'b0;
    assign hz_rs2      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_ctrl
// Description : Self-checking bench for reg_wb_ctrl. Expected register
//               writes are queued when stimulus is applied and compared in
//               order as the DUT raises wr_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            iss_valid;
    logic            iss_is_load;
    logic [4:0]      iss_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            hz_rs1;
    logic            hz_rs2;
    logic            wr_en;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [4:0]      exp_rd_q   [$];
    logic [XLEN-1:0] exp_data_q [$];

    always #5 clk = ~clk;

    reg_wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .iss_valid   (iss_valid),
        .iss_is_load (iss_is_load),
        .iss_rd      (iss_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hz_rs1      (hz_rs1),
        .hz_rs2      (hz_rs2),
        .wr_en       (wr_en),
        .rd_addr     (rd_addr),
        .wr_data     (wr_data)
    );

    task automatic expect_wr(input logic [4:0] rd, input logic [XLEN-1:0] d);
        exp_rd_q.push_back(rd);
        exp_data_q.push_back(d);
    endtask

    // Advance one cycle; any write presented in the new cycle is scored.
    task automatic tick();
        logic [4:0]      er;
        logic [XLEN-1:0] ed;
        @(posedge clk);
        #1;
        if (rst_n && wr_en) begin
            checks++;
            if (exp_rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write rd_addr=%0d wr_data=%h required no write", rd_addr, wr_data);
            end else begin
                er = exp_rd_q.pop_front();
                ed = exp_data_q.pop_front();
                if (rd_addr !== er || wr_data !== ed) begin
                    errors++;
                    $display("FAIL write_order rd_addr=%0d wr_data=%h required rd=%0d data=%h",
                             rd_addr, wr_data, er, ed);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_rd_q.size() != 0; i++) begin
            tick();
        end
        repeat (2) tick();
        checks++;
        if (exp_rd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes outstanding=%0d required 0", name, exp_rd_q.size());
        end
        exp_rd_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_reset();
        // During initial reset
        chk_rs1 = 5'd9;
        chk_rs2 = 5'd7;
        #1;
        checks++;
        if (wr_en !== 1'b0 || rd_addr !== 5'd0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs wr_en=%b rd_addr=%0d wr_data=%h required 0/0/0", wr_en, rd_addr, wr_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b1 || hz_rs1 !== 1'b0 || hz_rs2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready alu_ready=%b ld_ready=%b hz=%b%b required 1 1 00",
                     alu_ready, ld_ready, hz_rs1, hz_rs2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        // Stream: ALU x0 results keep priority so loads accumulate unwritten
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        ld_valid  = 1'b1; ld_rd  = 5'd20; ld_data = 32'h2000;
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        tick();
        checks++;
        if (hz_rs1 !== SB || hz_rs2 !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_hz hz_rs1=%b hz_rs2=%b required %b 0", hz_rs1, hz_rs2, SB);
        end
        // Mid-stream asynchronous reset
        #2 rst_n = 1'b0;
        #1;
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0 || ld_ready !== 1'b1 || hz_rs1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs wr_en=%b ld_ready=%b hz_rs1=%b required 0 1 0", wr_en, ld_ready, hz_rs1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        // ALU x0 result is consumed but never written
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL x0_write wr_en=%b required 0", wr_en);
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        expect_wr(5'd5, 32'h1234);
        tick();
        alu_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd5 || wr_data !== 32'h1234) begin
            errors++;
            $display("FAIL alu_latency wr_en=%b rd_addr=%0d wr_data=%h required 1 5 00001234", wr_en, rd_addr, wr_data);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0 || rd_addr !== 5'd5 || wr_data !== 32'h1234) begin
            errors++;
            $display("FAIL idle_hold wr_en=%b rd_addr=%0d wr_data=%h required 0 5 00001234", wr_en, rd_addr, wr_data);
        end
        drain("reset");
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d;
        for (int i = 0; i < 6; i++) begin
            d = $urandom();
            alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = d;
            expect_wr(5'(i + 1), d);
            tick();
        end
        alu_valid = 1'b0;
        drain("back_to_back");
    endtask

    task automatic test_collision();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3A3_0003;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hB4B4_0004;
        expect_wr(5'd3, 32'hA3A3_0003);
        expect_wr(5'd4, 32'hB4B4_0004);
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || rd_addr !== 5'd3) begin
            errors++;
            $display("FAIL collision_first wr_en=%b rd_addr=%0d required 1 3", wr_en, rd_addr);
        end
        drain("collision");
    endtask

    task automatic test_fifo_fill();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_00A1;
        for (int k = 0; k < 4; k++) expect_wr(5'd1, 32'h0000_00A1);
        expect_wr(5'd10, 32'h1000);
        expect_wr(5'd1,  32'h0000_00A1);
        expect_wr(5'd11, 32'h1001);
        expect_wr(5'd12, 32'h1002);
        expect_wr(5'd13, 32'h1003);
        ld_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ld_rd   = 5'(10 + k);
            ld_data = 32'h1000 + 32'(k);
            if (k == 3) begin
                checks++;
                if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_count3_ready ld_ready=%b alu_ready=%b required 1 1", ld_ready, alu_ready);
                end
            end
            tick();
        end
        ld_valid = 1'b0;
        checks++;
        if (ld_ready !== 1'b0 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_ready ld_ready=%b alu_ready=%b required 0 0", ld_ready, alu_ready);
        end
        tick();
        checks++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_resume_ready ld_ready=%b alu_ready=%b required 1 1", ld_ready, alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        drain("fifo_fill");
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        chk_rs1 = 5'd7; chk_rs2 = 5'd8;
        #1;
        checks++;
        if (hz_rs1 !== SB || hz_rs2 !== 1'b0) begin
            errors++;
            $display("FAIL sb_set hz_rs1=%b hz_rs2=%b required %b 0", hz_rs1, hz_rs2, SB);
        end
        tick();
        tick();
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h77;
        expect_wr(5'd7, 32'h77);
        tick();
        ld_valid = 1'b0;
        // Commit cycle: load pops now; re-issue to the same rd
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd7;
        #1;
        checks++;
        if (hz_rs1 !== SB) begin
            errors++;
            $display("FAIL sb_commit_cycle hz_rs1=%b required %b", hz_rs1, SB);
        end
        tick();
        iss_valid = 1'b0;
        checks++;
        if (hz_rs1 !== SB) begin
            errors++;
            $display("FAIL sb_set_wins hz_rs1=%b required %b", hz_rs1, SB);
        end
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h78;
        expect_wr(5'd7, 32'h78);
        tick();
        ld_valid = 1'b0;
        tick();
        checks++;
        if (hz_rs1 !== 1'b0 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL sb_clear hz_rs1=%b wr_en=%b required 0 1", hz_rs1, wr_en);
        end
        chk_rs1 = 5'd0;
        iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd0;
        tick();
        iss_valid = 1'b0;
        #1;
        checks++;
        if (hz_rs1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_x0 hz_rs1=%b required 0", hz_rs1);
        end
        drain("scoreboard");
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        iss_valid = 1'b0; iss_is_load = 1'b0; iss_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0;
        test_reset();
        test_back_to_back();
        test_collision();
        test_fifo_fill();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
